frame_bram_scheduler: RTL
=========================

# frame_bram_scheduler

Sequences and arbitrates the single-port frame BRAM that is shared between the edge-detection engine and the VGA/HDMI pixel reader. It sits between `vga_generator`/`edge_detect` and one `image` BRAM instance. It runs a frame-level phase machine (idle → process → display), grants the port per cycle according to the phase, and returns read data to the right requester with a fixed latency. During phases where video does not own the port, video receives a fill colour.

## Interface
Parameters:
- `AW`, 19: BRAM address width.
- `DW`, 8: pixel data width.
- `NPIX`, 307200: valid pixel count (640×480); addresses ≥ NPIX are out of range.
- `FILL`, 8'hFF: pixel value returned to video when it is not served from RAM.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that requests a processing pass.
- `proc_done` in 1: single-cycle pulse from the engine marking the end of its pass.
- `vid_frame_start` in 1: single-cycle pulse at the first pixel of a video frame.
- `vid_req` in 1: video read request; never stalled by the scheduler.
- `vid_addr` in AW: video read address.
- `vid_rvalid` out 1: video read data valid.
- `vid_rdata` out DW: video read data.
- `proc_req` in 1: engine access request; held until granted.
- `proc_we` in 1: 1 = write, 0 = read; qualified by `proc_req`.
- `proc_addr` in AW: engine address.
- `proc_wdata` in DW: engine write data.
- `proc_gnt` out 1: request accepted this cycle (combinational).
- `proc_rvalid` out 1: engine read data valid.
- `proc_rdata` out DW: engine read data.
- `ram_en`, `ram_we` out 1: BRAM port enable and write enable (registered).
- `ram_addr` out AW: BRAM port address (registered).
- `ram_wdata` out DW: BRAM port write data (registered).
- `ram_rdata` in DW: BRAM read data; synchronous, 1-cycle read.
- `phase` out 2: 0 IDLE, 1 PROC, 2 PEND, 3 DISP.
- `addr_err` out 1: sticky out-of-range flag; see Configuration.

## Operation
Phase machine. Reset state is IDLE.
- IDLE → PROC on `start`.
- PROC → DISP on `proc_done`.
- DISP → PEND on `start` without `vid_frame_start`.
- DISP → PROC on `start` and `vid_frame_start` in the same cycle.
- PEND → PROC on `vid_frame_start`.
- `start` in PROC or PEND is ignored. `proc_done` outside PROC is ignored.

Grant rules, evaluated per cycle:
- IDLE: no grants. Video requests are answered with FILL.
- PROC: `proc_gnt = proc_req`. The engine owns the port. Video requests are answered with FILL and not issued to RAM.
- DISP and PEND: video has absolute priority. `proc_gnt = proc_req & ~vid_req`.
- Granted writes issue `ram_we=1`. They produce no rvalid.
- Each issued or fill-answered read carries an owner tag (video/proc) and a fill bit down a 2-stage pipeline.
- Reads already in flight complete to their original requester even if the phase changes.
- Data mux at return: video-fill → FILL; otherwise `ram_rdata`.
- At most one RAM access per cycle. `ram_en=0` when nothing is granted.

## Timing
- A request accepted in cycle N (grant, or video fill) drives `ram_*` in N+1.
- The matching `*_rvalid`/`*_rdata` appear in N+2. Latency is exactly 2 for both RAM and fill reads.
- Back-to-back accepted reads produce back-to-back rvalids. Throughput is 1 access/cycle.
- Reset values:
  - `phase`=0.
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata` = 0.
  - `vid_rvalid`, `proc_rvalid` = 0.
  - `vid_rdata`, `proc_rdata` = 0.
  - `addr_err`=0.
  - The pipeline is flushed.
- Reset mid-operation drops in-flight reads: no rvalid follows reset.
- `proc_gnt` is combinational from `proc_req`, `vid_req` and `phase`. It is 0 while `rst` is high.

## Configuration
- `FRAME_SCHED_ADDR_GUARD_EN` defined: any accepted access with address ≥ NPIX is not issued to RAM (`ram_en=0`).
  - Such reads return FILL at normal latency with rvalid.
  - Such writes are dropped.
  - `addr_err` sets and holds until `rst`.
  - Grant timing is unchanged.
- `FRAME_SCHED_ADDR_GUARD_EN` not defined: addresses pass unchecked and `addr_err` is tied 0.

## Test plan
- Reset, then `vid_req`=1 @addr 5 in IDLE → `vid_rvalid` 2 cycles later with `vid_rdata`=8'hFF; `ram_en` stays 0.
- `start`; engine writes 8'h3C @addr 100, reads @100 → `proc_gnt`=1 each cycle, `ram_we` pulse at N+1, `proc_rdata`=8'h3C at read N+2.
- `proc_done` → `phase`=3. Simultaneous `vid_req` and `proc_req` read for 4 cycles → `proc_gnt`=0 throughout; video gets RAM data; proc is granted the first cycle `vid_req` drops.
- In DISP, `start` alone → `phase`=2. `vid_frame_start` 10 cycles later → `phase`=1 next cycle. `start`+`vid_frame_start` together in DISP → `phase`=1 directly.
- Proc read granted, `proc_done` the next cycle → `proc_rvalid` still at N+2 with RAM data. Assert `rst` 1 cycle after a grant → no rvalid and all outputs at reset values.
- With `FRAME_SCHED_ADDR_GUARD_EN`: proc write @addr 307200 → `ram_en`=0, `addr_err`=1 and stays 1. Video read @400000 → FILL at latency 2.

Source files
------------

// File: rtl/frame_bram_scheduler.sv
// Frame BRAM scheduler: shares one single-port frame BRAM between the
// edge-detection engine and the video pixel reader. A frame-level phase
// machine (idle/process/pending/display) decides who owns the port; reads
// return to their requester after exactly two cycles, and video gets a fill
// colour when it is not served from RAM.
// Optional feature: define FRAME_SCHED_ADDR_GUARD_EN to block out-of-range
// accesses (address >= NPIX) and raise a sticky addr_err.
module frame_bram_scheduler #(
  parameter int unsigned   AW   = 19,
  parameter int unsigned   DW   = 8,
  parameter int unsigned   NPIX = 307200,
  parameter logic [DW-1:0] FILL = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          proc_done,
  input  logic          vid_frame_start,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          proc_req,
  input  logic          proc_we,
  input  logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_wdata,
  output logic          proc_gnt,
  output logic          proc_rvalid,
  output logic [DW-1:0] proc_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    phase,
  output logic          addr_err
);

  typedef enum logic [1:0] {
    PhIdle = 2'd0,
    PhProc = 2'd1,
    PhPend = 2'd2,
    PhDisp = 2'd3
  } phase_e;

  phase_e phase_q, phase_d;

  logic vid_owns, vid_oob, proc_oob, vid_issue, proc_issue;

  logic          ram_en_d, ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_wdata_d;

  // Two-stage return pipeline; video and engine may both have a read
  // accepted in the same cycle (engine in PROC, video answered with fill).
  logic s1_vid_v, s1_vid_fill, s1_proc_v, s1_proc_fill;
  logic s2_vid_v, s2_vid_fill, s2_proc_v, s2_proc_fill;

  // Phase next-state logic
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PhIdle: if (start) phase_d = PhProc;
      PhProc: if (proc_done) phase_d = PhDisp;
      PhDisp: if (start) phase_d = vid_frame_start ? PhProc : PhPend;
      PhPend: if (vid_frame_start) phase_d = PhProc;
      default: phase_d = PhIdle;
    endcase
  end

  // Phase state register
  always_ff @(posedge clk) begin
    if (rst) phase_q <= PhIdle;
    else     phase_q <= phase_d;
  end

  assign phase    = phase_q;
  assign vid_owns = (phase_q == PhDisp) || (phase_q == PhPend);
  assign proc_gnt = ~rst & proc_req & ((phase_q == PhProc) | (vid_owns & ~vid_req));

`ifdef FRAME_SCHED_ADDR_GUARD_EN
  localparam logic [AW:0] NpixW = (AW + 1)'(NPIX);

  assign vid_oob  = {1'b0, vid_addr} >= NpixW;
  assign proc_oob = {1'b0, proc_addr} >= NpixW;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                                          addr_err <= 1'b0;
    else if ((vid_req & vid_oob) | (proc_gnt & proc_oob)) addr_err <= 1'b1;
  end
`else
  assign vid_oob  = 1'b0;
  assign proc_oob = 1'b0;
  assign addr_err = 1'b0;
`endif

  assign vid_issue  = vid_req & vid_owns & ~vid_oob;
  assign proc_issue = proc_gnt & ~proc_oob;

  // RAM port next-state: at most one of vid_issue/proc_issue is ever set
  always_comb begin
    ram_en_d    = vid_issue | proc_issue;
    ram_we_d    = proc_issue & proc_we;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (vid_issue) begin
      ram_addr_d = vid_addr;
    end else if (proc_issue) begin
      ram_addr_d = proc_addr;
      if (proc_we) ram_wdata_d = proc_wdata;
    end
  end

  // RAM port and return pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      s1_vid_v     <= 1'b0;
      s1_vid_fill  <= 1'b0;
      s1_proc_v    <= 1'b0;
      s1_proc_fill <= 1'b0;
      s2_vid_v     <= 1'b0;
      s2_vid_fill  <= 1'b0;
      s2_proc_v    <= 1'b0;
      s2_proc_fill <= 1'b0;
    end else begin
      ram_en       <= ram_en_d;
      ram_we       <= ram_we_d;
      ram_addr     <= ram_addr_d;
      ram_wdata    <= ram_wdata_d;
      s1_vid_v     <= vid_req;
      s1_vid_fill  <= ~vid_issue;
      s1_proc_v    <= proc_gnt & ~proc_we;
      s1_proc_fill <= proc_oob;
      s2_vid_v     <= s1_vid_v;
      s2_vid_fill  <= s1_vid_fill;
      s2_proc_v    <= s1_proc_v;
      s2_proc_fill <= s1_proc_fill;
    end
  end

  // Return data mux; RAM data is valid in the same cycle as stage 2
  always_comb begin
    vid_rvalid  = s2_vid_v;
    proc_rvalid = s2_proc_v;
    vid_rdata   = '0;
    proc_rdata  = '0;
    if (s2_vid_v)  vid_rdata  = s2_vid_fill  ? FILL : ram_rdata;
    if (s2_proc_v) proc_rdata = s2_proc_fill ? FILL : ram_rdata;
  end

endmodule
